ddr_wr_arb: RTL

Two-port round-robin arbiter that shares the single DDR S2MM write path (`ddr_wreq_*`, `ddr_wdata*`, `ddr_wresp*`) between two write requesters, e.g. the test data generator and a second capture engine. It grants one whole burst at a time: request, then data through `last`. It tracks outstanding bursts in an owner FIFO, so each in-order write response is returned to the port that issued it. It sits between the requesters and `bd_wrap`, in the same clock domain as the DDR control interface.

---
 rtl/ddr_wr_arb.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ddr_wr_arb.sv
// Two-port round-robin arbiter for the DDR S2MM write path: grants whole bursts
// (request, then data through last) and routes in-order responses via an owner FIFO.
module ddr_wr_arb #(
  parameter int ADDR_WIDTH  = 32,
  parameter int SIZE_WIDTH  = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   s_wreq_valid,
  output logic [1:0]                   s_wreq_ready,
  input  logic [2*ADDR_WIDTH-1:0]      s_wreq_addr,
  input  logic [2*SIZE_WIDTH-1:0]      s_wreq_size,
  input  logic [1:0]                   s_wdata_valid,
  input  logic [1:0]                   s_wdata_last,
  input  logic [2*DATA_WIDTH-1:0]      s_wdata,
  output logic [1:0]                   s_wdata_ready,
  output logic [1:0]                   s_wresp_valid,
  output logic [1:0]                   s_wresp,
  input  logic                         ddr_wreq_ready,
  output logic                         ddr_wreq_valid,
  output logic [ADDR_WIDTH-1:0]        ddr_wreq_addr,
  output logic [SIZE_WIDTH-1:0]        ddr_wreq_size,
  input  logic                         ddr_wdata_ready,
  output logic                         ddr_wdata_valid,
  output logic                         ddr_wdata_last,
  output logic [DATA_WIDTH-1:0]        ddr_wdata,
  input  logic                         ddr_wresp_valid,
  input  logic [1:0]                   ddr_wresp,
  output logic [$clog2(OUTSTANDING):0] outstanding,
  output logic                         orphan_err
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam logic [PW:0]   FULL_C = (PW+1)'(OUTSTANDING);
  localparam logic [PW:0]   CNT1   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR1   = PW'(1);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t                  state, state_nx;
  logic                    gnt, last_gnt, g;
  logic                    push, pop, full, empty, head;
  logic [OUTSTANDING-1:0]  owner;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [PW:0]             count;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [SIZE_WIDTH-1:0]   size_q;

  assign full           = (count == FULL_C);
  assign empty          = (count == '0);
  assign head           = owner[rd_ptr];
  assign outstanding    = count;
  assign ddr_wreq_addr  = addr_q;
  assign ddr_wreq_size  = size_q;

  // Port 1 wins unless port 0 also requests and port 1 was the last winner.
  assign g = s_wreq_valid[1] & ~(s_wreq_valid[0] & last_gnt);

  always_comb begin
    state_nx        = state;
    push            = 1'b0;
    s_wreq_ready    = 2'b00;
    s_wdata_ready   = 2'b00;
    ddr_wreq_valid  = 1'b0;
    ddr_wdata_valid = 1'b0;
    ddr_wdata_last  = 1'b0;
    ddr_wdata       = '0;
    case (state)
      IDLE: begin
        if ((|s_wreq_valid) && !full && !rst) begin
          push            = 1'b1;
          s_wreq_ready[g] = 1'b1;
          state_nx        = REQ;
        end
      end
      REQ: begin
        ddr_wreq_valid = 1'b1;
        if (ddr_wreq_ready) state_nx = DATA;
      end
      DATA: begin
        ddr_wdata_valid    = gnt ? s_wdata_valid[1] : s_wdata_valid[0];
        ddr_wdata_last     = gnt ? s_wdata_last[1]  : s_wdata_last[0];
        ddr_wdata          = gnt ? s_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : s_wdata[DATA_WIDTH-1:0];
        s_wdata_ready[gnt] = ddr_wdata_ready;
        if (ddr_wdata_valid && ddr_wdata_ready && ddr_wdata_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Responses come back in issue order, so the FIFO head names the owner.
  always_comb begin
    pop           = ddr_wresp_valid && !empty && !rst;
    s_wresp_valid = 2'b00;
    if (pop) s_wresp_valid[head] = 1'b1;
    s_wresp       = pop ? ddr_wresp : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_gnt   <= 1'b1;
      addr_q     <= '0;
      size_q     <= '0;
      owner      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      orphan_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) begin
        addr_q        <= g ? s_wreq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_wreq_addr[ADDR_WIDTH-1:0];
        size_q        <= g ? s_wreq_size[2*SIZE_WIDTH-1:SIZE_WIDTH] : s_wreq_size[SIZE_WIDTH-1:0];
        gnt           <= g;
        last_gnt      <= g;
        owner[wr_ptr] <= g;
        wr_ptr        <= wr_ptr + PTR1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR1;
      case ({push, pop})
        2'b10:   count <= count + CNT1;
        2'b01:   count <= count - CNT1;
        default: count <= count;
      endcase
      if (ddr_wresp_valid && empty) orphan_err <= 1'b1;
    end
  end

endmodule
